// File: rtl/order_loader.sv
// Runtime loader for the layer-order table: packs a 32-bit descriptor stream
// into wide table entries and exposes them through a combinational read port.
module order_loader #(
  parameter int unsigned ORDER_DEPTH = 64,
  parameter int unsigned ORDER_WORDS = 32,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic                        system_clk,
  input  logic                        rst_n,
  input  logic                        load_start,
  input  logic [ADDR_W:0]             load_order_num,
  input  logic [31:0]                 word_in_data,
  input  logic                        word_in_valid,
  output logic                        word_in_ready,
  input  logic [ADDR_W-1:0]           order_rd_addr,
  output logic [32*ORDER_WORDS-1:0]   order_rd_data,
  output logic                        load_done,
  output logic                        table_valid,
  output logic [ADDR_W:0]             order_count
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ENTRY_W = WORD_W * ORDER_WORDS;
  localparam int unsigned ASM_W   = ENTRY_W - WORD_W;
  localparam int unsigned WCNT_W  = $clog2(ORDER_WORDS);
  localparam int unsigned CNT_W   = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [CNT_W-1:0]    entry_cnt_q;
  logic [CNT_W-1:0]    num_q;
  logic                ready_q;
  logic                done_q;
  logic                valid_q;
  logic [ASM_W-1:0]    asm_q;
  logic [ENTRY_W-1:0]  table_q [ORDER_DEPTH];

  logic                accept_c;
  logic                last_word_c;
  logic                wr_en_c;
  logic [CNT_W-1:0]    num_clamp_c;
  logic [CNT_W-1:0]    entry_next_c;
  logic [ENTRY_W-1:0]  entry_d;

  // ready is only ever high in LOAD, so it doubles as the accept qualifier
  always_comb begin
    accept_c     = word_in_valid & ready_q;
    last_word_c  = (word_cnt_q == WCNT_W'(ORDER_WORDS - 1));
    wr_en_c      = accept_c & last_word_c;
    entry_next_c = entry_cnt_q + CNT_W'(1);
    entry_d      = {word_in_data, asm_q};
    num_clamp_c  = load_order_num;
    if (load_order_num > CNT_W'(ORDER_DEPTH)) begin
      num_clamp_c = CNT_W'(ORDER_DEPTH);
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      entry_cnt_q <= '0;
      num_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            num_q       <= num_clamp_c;
            word_cnt_q  <= '0;
            entry_cnt_q <= '0;
            valid_q     <= 1'b0;
            if (num_clamp_c == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              ready_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept_c) begin
            if (last_word_c) begin
              word_cnt_q  <= '0;
              entry_cnt_q <= entry_next_c;
              if (entry_next_c == num_q) begin
                state_q <= ST_DONE;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              word_cnt_q <= word_cnt_q + WCNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Assembly register holds all but the final word of the entry in flight
  always_ff @(posedge system_clk) begin
    if (accept_c && !last_word_c) begin
      asm_q[int'(word_cnt_q) * WORD_W +: WORD_W] <= word_in_data;
    end
  end

  // Table RAM is never cleared; a reset edge suppresses the pending write
  always_ff @(posedge system_clk) begin
    if (rst_n && wr_en_c) begin
      table_q[entry_cnt_q[ADDR_W-1:0]] <= entry_d;
    end
  end

  assign order_rd_data = table_q[order_rd_addr];
  assign word_in_ready = ready_q;
  assign load_done     = done_q;
  assign table_valid   = valid_q;
  assign order_count   = entry_cnt_q;

endmodule
